// File: rtl/timekeep_sequencer_pkg.sv
// rtl/timekeep_sequencer_pkg.sv - shared moduli, FSM states and request indices for the timekeeping sequencer
package timekeep_sequencer_pkg;

    localparam int SEC_MAX_DEF     = 60;
    localparam int MIN_MAX_DEF     = 60;
    localparam int HRS_MAX_DEF     = 12;
    localparam int AL_MIN_STEP_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEC_INC = 3'd1,
        ST_MIN_INC = 3'd2,
        ST_HRS_INC = 3'd3,
        ST_AL_MIN  = 3'd4,
        ST_AL_HRS  = 3'd5,
        ST_TOGGLE  = 3'd6,
        ST_ALCHK   = 3'd7
    } state_t;

    // Request indices double as priority: lower index wins.
    localparam int REQ_TICK   = 0;
    localparam int REQ_SEC    = 1;
    localparam int REQ_MIN    = 2;
    localparam int REQ_HRS    = 3;
    localparam int REQ_AL_MIN = 4;
    localparam int REQ_TOGGLE = 5;
    localparam int NUM_REQ    = 6;

    // First FSM state entered when a request source is granted.
    function automatic state_t grant_state(input int idx);
        case (idx)
            REQ_TICK:   grant_state = ST_SEC_INC;
            REQ_SEC:    grant_state = ST_SEC_INC;
            REQ_MIN:    grant_state = ST_MIN_INC;
            REQ_HRS:    grant_state = ST_HRS_INC;
            REQ_AL_MIN: grant_state = ST_AL_MIN;
            REQ_TOGGLE: grant_state = ST_TOGGLE;
            default:    grant_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/timekeep_sequencer_wrap_inc.sv
// rtl/timekeep_sequencer_wrap_inc.sv - combinational modulo-MAX increment with carry flag
module timekeep_sequencer_wrap_inc #(
    parameter int W   = 6,
    parameter int MAX = 60
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] value_next,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    // Carry fires on the last legal value, which wraps straight to zero.
    assign carry      = (value == LAST);
    assign value_next = carry ? '0 : value + W'(1);

endmodule

// File: rtl/timekeep_sequencer.sv
// rtl/timekeep_sequencer.sv - time/alarm register file with queued request arbitration and stepwise carries
module timekeep_sequencer
    import timekeep_sequencer_pkg::*;
#(
    parameter int SEC_MAX     = SEC_MAX_DEF,
    parameter int MIN_MAX     = MIN_MAX_DEF,
    parameter int HRS_MAX     = HRS_MAX_DEF,
    parameter int AL_MIN_STEP = AL_MIN_STEP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       sec_adj,
    input  logic       min_adj,
    input  logic       hrs_adj,
    input  logic       al_adj,
    input  logic       al_toggle,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [3:0] hours,
    output logic [5:0] al_minutes,
    output logic [3:0] al_hours,
    output logic       al_on,
    output logic       alarm,
    output logic       busy
);

    state_t state;
    state_t grant_target;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] grant_vec;

    logic [5:0] sec_next;
    logic [5:0] min_next;
    logic [3:0] hrs_next;
    logic [3:0] al_hrs_next;
    logic       sec_carry;
    logic       min_carry;
    logic       hrs_carry;
    logic       al_hrs_carry;
    logic [6:0] al_sum;
    logic       unused_carry;

    assign req = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz};

    timekeep_sequencer_wrap_inc #(.W(6), .MAX(SEC_MAX)) u_sec_inc (
        .value(seconds), .value_next(sec_next), .carry(sec_carry)
    );
    timekeep_sequencer_wrap_inc #(.W(6), .MAX(MIN_MAX)) u_min_inc (
        .value(minutes), .value_next(min_next), .carry(min_carry)
    );
    timekeep_sequencer_wrap_inc #(.W(4), .MAX(HRS_MAX)) u_hrs_inc (
        .value(hours), .value_next(hrs_next), .carry(hrs_carry)
    );
    timekeep_sequencer_wrap_inc #(.W(4), .MAX(HRS_MAX)) u_al_hrs_inc (
        .value(al_hours), .value_next(al_hrs_next), .carry(al_hrs_carry)
    );

    // Hour wraps have nothing further to carry into.
    assign unused_carry = hrs_carry | al_hrs_carry;

    // Alarm minutes step by more than one, so the sum is kept one bit wider to detect overflow.
    assign al_sum = {1'b0, al_minutes} + 7'(AL_MIN_STEP);

    // Fixed-priority grant, only offered while the sequencer is idle.
    always_comb begin
        grant_vec    = '0;
        grant_target = ST_IDLE;
        if (state == ST_IDLE) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    grant_vec    = '0;
                    grant_vec[i] = 1'b1;
                    grant_target = grant_state(i);
                end
            end
        end
    end

    // Pending bits: set by pulses, cleared on grant; a pulse in the grant cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | req;
        end
    end

    // Sequencer: one register write per cycle, carries walked as separate states.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            seconds    <= '0;
            minutes    <= '0;
            hours      <= '0;
            al_minutes <= '0;
            al_hours   <= '0;
            al_on      <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= grant_target;
                ST_SEC_INC: begin
                    seconds <= sec_next;
                    state   <= sec_carry ? ST_MIN_INC : ST_ALCHK;
                end
                ST_MIN_INC: begin
                    minutes <= min_next;
                    state   <= min_carry ? ST_HRS_INC : ST_ALCHK;
                end
                ST_HRS_INC: begin
                    hours <= hrs_next;
                    state <= ST_ALCHK;
                end
                ST_AL_MIN: begin
                    if (al_sum >= 7'(MIN_MAX)) begin
                        al_minutes <= 6'(al_sum - 7'(MIN_MAX));
                        state      <= ST_AL_HRS;
                    end else begin
                        al_minutes <= al_sum[5:0];
                        state      <= ST_ALCHK;
                    end
                end
                ST_AL_HRS: begin
                    al_hours <= al_hrs_next;
                    state    <= ST_ALCHK;
                end
                ST_TOGGLE: begin
                    al_on <= ~al_on;
                    if (al_on) begin
                        alarm <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_ALCHK;
                    end
                end
                ST_ALCHK: begin
                    if (al_on && hours == al_hours && minutes == al_minutes) begin
                        alarm <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_timekeep_sequencer.sv
// tb/tb_timekeep_sequencer.sv - directed self-checking bench for timekeep_sequencer
module tb_timekeep_sequencer;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic       sec_adj;
    logic       min_adj;
    logic       hrs_adj;
    logic       al_adj;
    logic       al_toggle;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [3:0] hours;
    logic [5:0] al_minutes;
    logic [3:0] al_hours;
    logic       al_on;
    logic       alarm;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] V_TICK = 6'b000001;
    localparam logic [5:0] V_SEC  = 6'b000010;
    localparam logic [5:0] V_MIN  = 6'b000100;
    localparam logic [5:0] V_HRS  = 6'b001000;
    localparam logic [5:0] V_ALA  = 6'b010000;
    localparam logic [5:0] V_TOG  = 6'b100000;

    timekeep_sequencer dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .sec_adj(sec_adj),
        .min_adj(min_adj), .hrs_adj(hrs_adj), .al_adj(al_adj), .al_toggle(al_toggle),
        .seconds(seconds), .minutes(minutes), .hours(hours), .al_minutes(al_minutes),
        .al_hours(al_hours), .al_on(al_on), .alarm(alarm), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [5:0] v);
        tick_1hz  = v[0];
        sec_adj   = v[1];
        min_adj   = v[2];
        hrs_adj   = v[3];
        al_adj    = v[4];
        al_toggle = v[5];
    endtask

    task automatic drive(input logic [5:0] v);
        set_inputs(v);
        step();
        set_inputs(6'b0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wait_idle(input string tag);
        repeat (2) step();
        for (int i = 0; i < 40 && busy; i++) step();
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_all(input string tag, input int h, input int m, input int s,
                             input int ah, input int am, input int on, input int al);
        check({tag, "_hours"}, 32'(hours), 32'(h));
        check({tag, "_minutes"}, 32'(minutes), 32'(m));
        check({tag, "_seconds"}, 32'(seconds), 32'(s));
        check({tag, "_al_hours"}, 32'(al_hours), 32'(ah));
        check({tag, "_al_minutes"}, 32'(al_minutes), 32'(am));
        check({tag, "_al_on"}, 32'(al_on), 32'(on));
        check({tag, "_alarm"}, 32'(alarm), 32'(al));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic repeat_req(input logic [5:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(v);
            wait_idle(tag);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_inputs(6'b0);
        repeat (3) step();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // 60 ticks roll seconds into minutes; last one checked at exact latency
        repeat_req(V_TICK, 59, "tick_idle");
        check("tick59_seconds", 32'(seconds), 32'd59);
        drive(V_TICK);
        repeat (4) step();
        check("tick60_busy", 32'(busy), 32'd0);
        check("tick60_seconds", 32'(seconds), 32'd0);
        check("tick60_minutes", 32'(minutes), 32'd1);

        // 11:59:59 + tick -> 00:00:00 with no illegal intermediate values
        do_reset();
        repeat_req(V_HRS, 11, "set_hrs");
        repeat_req(V_MIN, 59, "set_min");
        repeat_req(V_SEC, 59, "set_sec");
        check_all("pre_wrap", 11, 59, 59, 0, 0, 0, 0);
        drive(V_TICK);
        for (int i = 0; i < 4; i++) begin
            step();
            check("wrap_sec_range", 32'(seconds < 6'd60), 32'd1);
            check("wrap_min_range", 32'(minutes < 6'd60), 32'd1);
            check("wrap_hrs_range", 32'(hours < 4'd12), 32'd1);
        end
        check_all("wrap", 0, 0, 0, 0, 0, 0, 0);
        wait_idle("wrap_idle");

        // four simultaneous requests from 00:00:00 -> 01:01:02
        set_inputs(V_TICK | V_SEC | V_MIN | V_HRS);
        step();
        set_inputs(6'b0);
        repeat (25) step();
        check_all("simul", 1, 1, 2, 0, 0, 0, 0);
        check("simul_busy", 32'(busy), 32'd0);

        // second sec_adj while its bit is still pending is absorbed
        drive(V_TICK);
        step();
        set_inputs(V_SEC);
        repeat (2) step();
        set_inputs(6'b0);
        repeat (12) step();
        check("absorb_seconds", 32'(seconds), 32'd4);

        // sec_adj in the cycle its bit is granted re-queues it
        set_inputs(V_SEC);
        repeat (2) step();
        set_inputs(6'b0);
        repeat (12) step();
        check("regrant_seconds", 32'(seconds), 32'd6);

        // alarm-set stepping and wrap
        do_reset();
        repeat_req(V_ALA, 6, "al_adj");
        check_all("al6", 0, 0, 0, 1, 0, 0, 0);
        repeat_req(V_ALA, 65, "al_adj");
        check_all("al1150", 0, 0, 0, 11, 50, 0, 0);
        drive(V_ALA);
        wait_idle("al_wrap_idle");
        check_all("al_wrap", 0, 0, 0, 0, 0, 0, 0);

        // alarm match at al 00:10 from 00:09:59
        do_reset();
        drive(V_ALA);
        wait_idle("alm_set");
        drive(V_TOG);
        wait_idle("alm_arm");
        check_all("armed", 0, 0, 0, 0, 10, 1, 0);
        repeat_req(V_MIN, 9, "alm_min");
        repeat_req(V_SEC, 59, "alm_sec");
        check_all("pre_match", 0, 9, 59, 0, 10, 1, 0);
        drive(V_TICK);
        repeat (3) step();
        check("match_minutes", 32'(minutes), 32'd10);
        check("match_alarm_before", 32'(alarm), 32'd0);
        step();
        check("match_alarm_after", 32'(alarm), 32'd1);
        wait_idle("match_idle");
        repeat_req(V_TICK, 60, "sticky_tick");
        check_all("sticky", 0, 11, 0, 0, 10, 1, 1);
        drive(V_TOG);
        wait_idle("off_idle");
        check_all("off", 0, 11, 0, 0, 10, 0, 0);

        // reset during MIN_INC of a carry discards state and queued requests
        do_reset();
        repeat_req(V_SEC, 59, "rst_sec");
        drive(V_TICK | V_HRS | V_ALA);
        repeat (2) step();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_seconds", 32'(seconds), 32'd0);
        reset = 1'b1;
        step();
        check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_reset_busy", 32'(busy), 32'd0);
        end
        check_all("post_reset", 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
